mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
Responder end of the MIG user (app_*) interface that the DDR3 controller FSM drives. It stands in for the Xilinx MIG plus DDR3 in simulation and in FPGA builds without external DRAM. It accepts read and write commands and write data with MIG-style ready handshakes, and stores data in an internal block-RAM array. Read data returns in order, after a fixed latency, with no backpressure.

Parameters:
ADDR_WIDTH, 29, width of app_addr
DATA_WIDTH, 128, width of the data bus; mask width is DATA_WIDTH/8
MEM_DEPTH_LOG2, 10, log2 of the number of DATA_WIDTH words stored
RD_LATENCY, 4, cycles from command execution to read data valid
FIFO_DEPTH, 4, entries in the command FIFO and in the write-data FIFO (power of two)
INIT_CYCLES, 16, cycles after reset before calibration is reported complete

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
app_addr  in  ADDR_WIDTH  command address; word index = app_addr[MEM_DEPTH_LOG2+2:3]
app_cmd  in  3  000 = write, 001 = read
app_en  in  1  command valid
app_rdy  out  1  command accept ready
app_wdf_data  in  DATA_WIDTH  write data
app_wdf_mask  in  DATA_WIDTH/8  byte mask; 1 = byte not written
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat; single-beat mode, expected equal to wren
app_wdf_rdy  out  1  write data accept ready
app_rd_data  out  DATA_WIDTH  read data
app_rd_data_valid  out  1  read data valid, one-cycle pulse per read
app_rd_data_end  out  1  equals app_rd_data_valid
init_calib_complete  out  1  initialisation done
cmd_error  out  1  sticky flag: an unsupported app_cmd was accepted

Behaviour:
Reset:
- All FIFOs, the read pipeline, the init counter and cmd_error are cleared.
- Every output is 0, including app_rd_data.
- Memory contents are not reset.
- Reset asserted mid-operation drops all queued commands, queued data and in-flight reads. No app_rd_data_valid is produced for them.

Initialisation:
- An init counter runs for INIT_CYCLES cycles after reset release, then init_calib_complete is set to 1.
- While it is 0, app_rdy and app_wdf_rdy are 0.

Command acceptance:
- app_rdy = init_calib_complete && cmd_count < FIFO_DEPTH, computed from registered state only; there is no combinational path from app_en.
- A command is accepted on a rising edge with app_en && app_rdy. {cmd, word index} is pushed into the command FIFO.

Write data acceptance:
- app_wdf_rdy = init_calib_complete && wdf_count < FIFO_DEPTH.
- A beat is accepted on app_wdf_wren && app_wdf_rdy. {data, mask} is pushed into the write-data FIFO.
- app_wdf_end is ignored for acceptance.

Ordering:
- Write data may arrive before, with, or after its command; FIFO order pairs the Nth write command with the Nth data beat.

Execution (at most one command per cycle, strictly in order, head of the command FIFO):
- READ: pop the command, read RAM, push the result into a RD_LATENCY-deep valid/data shift pipeline. app_rd_data_valid rises exactly RD_LATENCY+1 cycles after the acceptance edge when the FIFO was empty (5 cycles at default).
- WRITE:
  - If the write-data FIFO is empty, the head stalls and all later commands wait (head-of-line blocking).
  - Otherwise, pop both FIFOs and write the bytes whose mask bit is 0.
- Other codes: pop and discard, set cmd_error to 1 until reset.

Addressing, ordering and simultaneity:
- app_addr[2:0] and bits above MEM_DEPTH_LOG2+2 are ignored; the array aliases.
- A read after a write to the same word returns the new data, because execution is in order and the RAM is write-first or bypassed.
- Simultaneous push and pop on the same FIFO in one cycle is legal; the count is unchanged.
- A full FIFO with a pop in the same cycle still reports not-ready that cycle, since ready is a registered-count function.
- app_rd_data holds its last value when valid is 0.

Decomposition:
- Package mig_app_pkg holds:
  - CMD_WRITE (3'b000) and CMD_READ (3'b001)
  - typedef app_cmd_t
  - the command-entry struct {app_cmd_t cmd; word index}
- Sub-module sync_fifo (parameterised WIDTH and DEPTH, with count output) is instantiated twice: command FIFO and write-data FIFO.
- RAM and read pipeline stay in the top module.

Test Plan:
- Init: release rst_n, hold app_en=1 → app_rdy=0 and init_calib_complete=0 for 16 cycles, then both 1; no command is accepted before that.
- Write then read: write addr 0x08, data 128'h0123456789ABCDEF_FEDCBA9876543210, mask 0; read addr 0x08 → app_rd_data equals that data, valid and end high for exactly 1 cycle, 5 cycles after read acceptance.
- Byte mask:
  - Write all-ones to 0x10, then write 0 to 0x10 with mask 16'hFF00.
  - Read 0x10 → 128'hFFFFFFFFFFFFFFFF_0000000000000000.
  - A read of 0x10 | 3'b101 returns the same word.
- Data-late stall:
  - Write command to 0x18 with no data, followed by reads of 0x08 ×4.
  - app_rdy drops once 4 entries are queued; no rd valid occurs.
  - Supply the data beat → queue drains; 4 valid pulses follow, all returning 0x08's data.
- Back-to-back reads: 4 consecutive reads of 0x00, 0x08, 0x10, 0x18 after preloading distinct values → 4 consecutive valid cycles, same order, values matching.
- Error and reset:
  - app_cmd=3'b011 accepted → cmd_error=1 and stays 1.
  - Assert rst_n low with 2 reads in flight → no app_rd_data_valid afterwards, cmd_error=0, init sequence restarts.

Source files
------------

// File: rtl/mig_app_pkg.sv
// Shared command encodings and FIFO entry types for the MIG app-interface responder.
package mig_app_pkg;

   typedef logic [2:0] app_cmd_t;

   localparam app_cmd_t CMD_WRITE = 3'b000;
   localparam app_cmd_t CMD_READ  = 3'b001;

   // Word index is carried at a fixed maximum width; the top uses only its low bits.
   localparam int IDX_MAX_W = 16;

   typedef struct packed {
      app_cmd_t               cmd;
      logic [IDX_MAX_W-1:0]   word_idx;
   } cmd_entry_t;

endpackage

// File: rtl/mig_app_responder_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign do_push  = push && (count != CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign pop_data = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the Xilinx MIG + DDR3: app_* handshakes, in-order
// execution against an internal RAM, fixed-latency read return.
module mig_app_responder
   import mig_app_pkg::*;
#(
   parameter int ADDR_WIDTH     = 29,
   parameter int DATA_WIDTH     = 128,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int RD_LATENCY     = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int INIT_CYCLES    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     app_addr,
   input  logic [2:0]                app_cmd,
   input  logic                      app_en,
   output logic                      app_rdy,
   input  logic [DATA_WIDTH-1:0]     app_wdf_data,
   input  logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
   input  logic                      app_wdf_wren,
   input  logic                      app_wdf_end,
   output logic                      app_wdf_rdy,
   output logic [DATA_WIDTH-1:0]     app_rd_data,
   output logic                      app_rd_data_valid,
   output logic                      app_rd_data_end,
   output logic                      init_calib_complete,
   output logic                      cmd_error
);

   localparam int MASK_W    = DATA_WIDTH / 8;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int WDF_W     = DATA_WIDTH + MASK_W;
   localparam int INIT_W    = $clog2(INIT_CYCLES + 1);
   localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;

   cmd_entry_t                 cmd_in;
   cmd_entry_t                 cmd_head;
   logic [CNT_W-1:0]           cmd_count;
   logic                       cmd_empty;
   logic                       cmd_push;
   logic                       cmd_pop;

   logic [WDF_W-1:0]           wdf_in;
   logic [WDF_W-1:0]           wdf_head;
   logic [CNT_W-1:0]           wdf_count;
   logic                       wdf_empty;
   logic                       wdf_push;
   logic                       wdf_pop;

   logic                       exec_read;
   logic                       exec_write;
   logic                       exec_other;
   logic [MEM_DEPTH_LOG2-1:0]  head_idx;
   logic [DATA_WIDTH-1:0]      head_data;
   logic [MASK_W-1:0]          head_mask;

   logic [INIT_W-1:0]          init_cnt;
   logic [DATA_WIDTH-1:0]      mem [MEM_WORDS];
   logic [RD_LATENCY-1:0]      pipe_valid;
   logic [DATA_WIDTH-1:0]      pipe_data [RD_LATENCY];

   logic                       unused_inputs;

   // Ready depends only on registered counts, never on the current request.
   assign app_rdy     = init_calib_complete && (cmd_count < CNT_W'(FIFO_DEPTH));
   assign app_wdf_rdy = init_calib_complete && (wdf_count < CNT_W'(FIFO_DEPTH));

   assign cmd_push        = app_en && app_rdy;
   assign cmd_in.cmd      = app_cmd;
   assign cmd_in.word_idx = IDX_MAX_W'(app_addr[MEM_DEPTH_LOG2+2:3]);

   assign wdf_push = app_wdf_wren && app_wdf_rdy;
   assign wdf_in   = {app_wdf_data, app_wdf_mask};

   sync_fifo #(
      .WIDTH ($bits(cmd_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_push),
      .push_data (cmd_in),
      .pop       (cmd_pop),
      .pop_data  (cmd_head),
      .count     (cmd_count),
      .empty     (cmd_empty)
   );

   sync_fifo #(
      .WIDTH (WDF_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wdf_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wdf_push),
      .push_data (wdf_in),
      .pop       (wdf_pop),
      .pop_data  (wdf_head),
      .count     (wdf_count),
      .empty     (wdf_empty)
   );

   assign head_idx  = cmd_head.word_idx[MEM_DEPTH_LOG2-1:0];
   assign head_data = wdf_head[WDF_W-1:MASK_W];
   assign head_mask = wdf_head[MASK_W-1:0];

   // A write at the head without its data beat blocks everything behind it.
   always_comb begin
      exec_read  = 1'b0;
      exec_write = 1'b0;
      exec_other = 1'b0;
      if (!cmd_empty) begin
         if (cmd_head.cmd == CMD_READ) begin
            exec_read = 1'b1;
         end else if (cmd_head.cmd == CMD_WRITE) begin
            exec_write = !wdf_empty;
         end else begin
            exec_other = 1'b1;
         end
      end
   end

   assign cmd_pop = exec_read || exec_write || exec_other;
   assign wdf_pop = exec_write;

   always_ff @(posedge clk) begin
      if (exec_write) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!head_mask[b]) begin
               mem[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
            end
         end
      end
   end

   // Only one command executes per cycle, so a read always sees earlier writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid        <= '0;
         app_rd_data_valid <= 1'b0;
         app_rd_data       <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= exec_read;
         if (exec_read) begin
            pipe_data[0] <= mem[head_idx];
         end
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
         app_rd_data_valid <= pipe_valid[RD_LATENCY-1];
         if (pipe_valid[RD_LATENCY-1]) begin
            app_rd_data <= pipe_data[RD_LATENCY-1];
         end
      end
   end

   assign app_rd_data_end = app_rd_data_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt            <= '0;
         init_calib_complete <= 1'b0;
      end else if (!init_calib_complete) begin
         if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            init_calib_complete <= 1'b1;
         end else begin
            init_cnt <= init_cnt + INIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_error <= 1'b0;
      end else if (exec_other) begin
         cmd_error <= 1'b1;
      end
   end

   // Address LSBs and upper bits alias by design; wdf_end carries no information in single-beat mode.
   assign unused_inputs = ^{app_wdf_end, app_addr[2:0], app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3],
                            cmd_head.word_idx[IDX_MAX_W-1:MEM_DEPTH_LOG2]};

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed self-checking bench for mig_app_responder.
module tb_mig_app_responder;

   localparam logic [2:0]   C_WR  = 3'b000;
   localparam logic [2:0]   C_RD  = 3'b001;
   localparam logic [127:0] D1    = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] ONES  = {128{1'b1}};
   localparam logic [127:0] MEXP  = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
   localparam logic [127:0] DL    = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
   localparam logic [127:0] V0    = 128'h11111111_00000000_AAAAAAAA_00000001;
   localparam logic [127:0] V1    = 128'h22222222_00000000_BBBBBBBB_00000002;
   localparam logic [127:0] V2    = 128'h33333333_00000000_CCCCCCCC_00000003;
   localparam logic [127:0] V3    = 128'h44444444_00000000_DDDDDDDD_00000004;

   logic          clk;
   logic          rst_n;
   logic [28:0]   app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [127:0]  app_wdf_data;
   logic [15:0]   app_wdf_mask;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic          app_wdf_rdy;
   logic [127:0]  app_rd_data;
   logic          app_rd_data_valid;
   logic          app_rd_data_end;
   logic          init_calib_complete;
   logic          cmd_error;

   int            n_checks;
   int            n_pass;
   int            cyc;
   logic [127:0]  rd_q [$];
   int            rd_cyc [$];

   mig_app_responder dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .init_calib_complete (init_calib_complete),
      .cmd_error           (cmd_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every read-return pulse with the cycle it appeared in.
   always @(negedge clk) begin
      if (app_rd_data_valid) begin
         rd_q.push_back(app_rd_data);
         rd_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   function automatic logic [127:0] q_at(input int i);
      if (i < rd_q.size()) return rd_q[i];
      return '0;
   endfunction

   function automatic int cyc_at(input int i);
      if (i < rd_cyc.size()) return rd_cyc[i];
      return -100;
   endfunction

   task automatic applyStimulus(input logic [2:0] cmd, input logic [28:0] addr, input logic with_data,
                                input logic [127:0] data, input logic [15:0] mask);
      logic ok;
      logic was;
      app_en       = 1'b1;
      app_cmd      = cmd;
      app_addr     = addr;
      app_wdf_wren = with_data;
      app_wdf_end  = with_data;
      app_wdf_data = data;
      app_wdf_mask = mask;
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
         was = app_rdy && (!with_data || app_wdf_rdy);
         tick();
         ok = was;
      end
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      checkOutput("accept", 128'(ok), 128'd1);
   endtask

   task automatic wait_pulses(input int n, input int budget);
      for (int i = 0; i < budget && rd_q.size() < n; i++) tick();
      tick();
      checkOutput("pulse_count", 128'(rd_q.size()), 128'(n));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  accepted;
      logic was;
      logic ok;
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      rst_n        = 1'b0;
      app_addr     = '0;
      app_cmd      = '0;
      app_en       = 1'b0;
      app_wdf_data = '0;
      app_wdf_mask = '0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_rdy",   128'(app_rdy), 128'd0);
      checkOutput("rst_wrdy",  128'(app_wdf_rdy), 128'd0);
      checkOutput("rst_calib", 128'(init_calib_complete), 128'd0);
      checkOutput("rst_valid", 128'(app_rd_data_valid), 128'd0);
      checkOutput("rst_data",  app_rd_data, 128'd0);
      checkOutput("rst_err",   128'(cmd_error), 128'd0);

      // Init sequence with app_en held high
      rst_n    = 1'b1;
      app_en   = 1'b1;
      app_cmd  = C_RD;
      app_addr = '0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i < 16) begin
            checkOutput("init_rdy",   128'(app_rdy), 128'd0);
            checkOutput("init_calib", 128'(init_calib_complete), 128'd0);
         end else begin
            checkOutput("init_done_calib", 128'(init_calib_complete), 128'd1);
            checkOutput("init_done_rdy",   128'(app_rdy), 128'd1);
            checkOutput("init_done_wrdy",  128'(app_wdf_rdy), 128'd1);
         end
      end
      app_en = 1'b0;
      rd_q.delete();
      repeat (8) tick();
      checkOutput("init_no_cmd", 128'(rd_q.size()), 128'd0);

      // Write then read with exact latency
      applyStimulus(C_WR, 29'h08, 1'b1, D1, 16'h0000);
      repeat (2) tick();
      rd_q.delete();
      app_en   = 1'b1;
      app_cmd  = C_RD;
      app_addr = 29'h08;
      checkOutput("lat_rdy", 128'(app_rdy), 128'd1);
      tick();
      app_en = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkOutput("lat_early", 128'(app_rd_data_valid), 128'd0);
      end
      tick();
      checkOutput("lat_valid", 128'(app_rd_data_valid), 128'd1);
      checkOutput("lat_end",   128'(app_rd_data_end), 128'd1);
      checkOutput("lat_data",  app_rd_data, D1);
      tick();
      checkOutput("lat_pulse", 128'(app_rd_data_valid), 128'd0);
      checkOutput("lat_hold",  app_rd_data, D1);

      // Byte mask and address aliasing
      applyStimulus(C_WR, 29'h10, 1'b1, ONES, 16'h0000);
      applyStimulus(C_WR, 29'h10, 1'b1, 128'd0, 16'hFF00);
      rd_q.delete();
      applyStimulus(C_RD, 29'h10, 1'b0, 128'd0, 16'h0000);
      applyStimulus(C_RD, 29'h15, 1'b0, 128'd0, 16'h0000);
      wait_pulses(2, 20);
      checkOutput("mask_data",  q_at(0), MEXP);
      checkOutput("alias_data", q_at(1), MEXP);

      // Write command whose data arrives late blocks the queue
      rd_q.delete();
      applyStimulus(C_WR, 29'h18, 1'b0, 128'd0, 16'h0000);
      app_en   = 1'b1;
      app_cmd  = C_RD;
      app_addr = 29'h08;
      accepted = 0;
      for (int k = 0; k < 20 && accepted < 3; k++) begin
         was = app_rdy;
         tick();
         if (was) accepted++;
      end
      checkOutput("stall_acc", 128'(accepted), 128'd3);
      checkOutput("stall_rdy", 128'(app_rdy), 128'd0);
      repeat (6) tick();
      checkOutput("stall_rdy_hold", 128'(app_rdy), 128'd0);
      checkOutput("stall_no_rd",    128'(rd_q.size()), 128'd0);
      app_wdf_data = DL;
      app_wdf_mask = 16'h0000;
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
      checkOutput("stall_wrdy", 128'(app_wdf_rdy), 128'd1);
      tick();
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         was = app_rdy;
         tick();
         ok = was;
      end
      app_en = 1'b0;
      checkOutput("stall_fourth", 128'(ok), 128'd1);
      wait_pulses(4, 30);
      for (int i = 0; i < 4; i++) begin
         checkOutput("stall_data", q_at(i), D1);
      end

      // Back-to-back reads of preloaded words
      applyStimulus(C_WR, 29'h00, 1'b1, V0, 16'h0000);
      applyStimulus(C_WR, 29'h08, 1'b1, V1, 16'h0000);
      applyStimulus(C_WR, 29'h10, 1'b1, V2, 16'h0000);
      applyStimulus(C_WR, 29'h18, 1'b1, V3, 16'h0000);
      repeat (2) tick();
      rd_q.delete();
      rd_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         app_en   = 1'b1;
         app_cmd  = C_RD;
         app_addr = 29'(i * 8);
         checkOutput("b2b_rdy", 128'(app_rdy), 128'd1);
         tick();
      end
      app_en = 1'b0;
      wait_pulses(4, 30);
      checkOutput("b2b_d0", q_at(0), V0);
      checkOutput("b2b_d1", q_at(1), V1);
      checkOutput("b2b_d2", q_at(2), V2);
      checkOutput("b2b_d3", q_at(3), V3);
      checkOutput("b2b_consec", 128'(cyc_at(3) - cyc_at(0)), 128'd3);

      // Unsupported command code
      applyStimulus(3'b011, 29'h00, 1'b0, 128'd0, 16'h0000);
      repeat (2) tick();
      checkOutput("err_set", 128'(cmd_error), 128'd1);
      repeat (5) tick();
      checkOutput("err_sticky", 128'(cmd_error), 128'd1);

      // Reset with two reads in flight
      rd_q.delete();
      app_en   = 1'b1;
      app_cmd  = C_RD;
      app_addr = 29'h00;
      tick();
      app_addr = 29'h08;
      tick();
      app_en = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_valid", 128'(app_rd_data_valid), 128'd0);
      checkOutput("mrst_data",  app_rd_data, 128'd0);
      checkOutput("mrst_err",   128'(cmd_error), 128'd0);
      checkOutput("mrst_calib", 128'(init_calib_complete), 128'd0);
      checkOutput("mrst_rdy",   128'(app_rdy), 128'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (15) tick();
      checkOutput("mrst_no_rd",    128'(rd_q.size()), 128'd0);
      checkOutput("mrst_reinit",   128'(init_calib_complete), 128'd0);
      tick();
      checkOutput("mrst_calib_on", 128'(init_calib_complete), 128'd1);
      checkOutput("mrst_err_hold", 128'(cmd_error), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
